// File: rtl/sha256_block_padder_if.sv
// sha256_block_padder_if: start control, memory read port and block output
// of the SHA-256 block padder, bundled for port connection.
//
// Block handshake: blk_valid/blk_ready follow strict valid/ready rules.
// The padder raises blk_valid only when blk_data holds a complete block. It
// keeps blk_data, blk_index and blk_last stable, and keeps blk_valid high,
// until it samples blk_valid & blk_ready on a rising edge (the transfer edge).
// blk_ready has no effect while blk_valid is low.
interface sha256_block_padder_if;
  logic         start;
  logic [15:0]  input_addr;
  logic         mem_rd_en;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_rd_data;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic [7:0]   blk_index;
  logic         blk_last;
  logic         busy;
  logic         done;

  // Padder side
  modport master (
    input  start, input_addr, mem_rd_data, blk_ready,
    output mem_rd_en, mem_addr, blk_valid, blk_data, blk_index, blk_last,
           busy, done
  );

  // Environment side: controller, memory and compression core
  modport slave (
    output start, input_addr, mem_rd_data, blk_ready,
    input  mem_rd_en, mem_addr, blk_valid, blk_data, blk_index, blk_last,
           busy, done
  );
endinterface

// File: rtl/sha256_block_padder.sv
// sha256_block_padder: reads NUM_OF_WORDS 32-bit words from a synchronous
// word-addressed memory, appends SHA-256 padding (0x80000000, zero fill,
// 64-bit bit length) and hands out complete 512-bit blocks.
// Optional macro SHA256_PADDER_BYTESWAP_EN: byte-reverse every memory word
// before it is stored (little-endian message memories).
module sha256_block_padder #(
  parameter int NUM_OF_WORDS = 40
) (
  input  logic                         clk,
  input  logic                         rst,
  sha256_block_padder_if.master        bus,
  output logic [1:0]                   dbg_state
);

  localparam int          NB       = (32 * NUM_OF_WORDS + 65 + 511) / 512;
  localparam logic [7:0]  LAST_BLK = 8'(NB - 1);
  localparam logic [11:0] N12      = 12'(NUM_OF_WORDS);
  localparam logic [63:0] LEN      = 64'(NUM_OF_WORDS) << 5;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cyc_q;      // FETCH edge counter: 1..15 issue, 2..17 capture
  logic [7:0]  blk_q;
  logic [15:0] base_q;
  logic [31:0] words_q [16];

  logic        issue;
  logic [3:0]  issue_k;
  logic [7:0]  issue_blk;
  logic [15:0] issue_base;
  logic [11:0] issue_g;
  logic        finish;
  logic        is_last_blk;
  logic [3:0]  cap_k;
  logic [11:0] cap_g;
  logic [31:0] mem_word;
  logic [31:0] cap_word;

  assign dbg_state   = state_q;
  assign is_last_blk = (blk_q == LAST_BLK);

`ifdef SHA256_PADDER_BYTESWAP_EN
  assign mem_word = {bus.mem_rd_data[7:0],   bus.mem_rd_data[15:8],
                     bus.mem_rd_data[23:16], bus.mem_rd_data[31:24]};
`else
  assign mem_word = bus.mem_rd_data;
`endif

  // Next state and slot-issue decode; a block's slot 0 is issued on the
  // start edge or the transfer edge so every block takes exactly 17 edges
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    issue_k    = cyc_q[3:0];
    issue_blk  = blk_q;
    issue_base = base_q;
    finish     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = FETCH;
          issue      = 1'b1;
          issue_k    = 4'd0;
          issue_blk  = 8'd0;
          issue_base = bus.input_addr;
        end
      end
      FETCH: begin
        issue = (cyc_q <= 5'd15);
        if (cyc_q == 5'd17) state_d = HOLD;
      end
      HOLD: begin
        if (bus.blk_ready) begin
          if (is_last_blk) begin
            state_d = IDLE;
            finish  = 1'b1;
          end else begin
            state_d   = FETCH;
            issue     = 1'b1;
            issue_k   = 4'd0;
            issue_blk = blk_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    issue_g = {issue_blk, issue_k};
  end

  // Content of the slot whose read data arrives this cycle: message word,
  // the 1-bit marker, the bit length in the last two slots, or zero
  always_comb begin
    cap_k = 4'(cyc_q - 5'd2);
    cap_g = {blk_q, cap_k};
    if (cap_g < N12)                          cap_word = mem_word;
    else if (cap_g == N12)                    cap_word = 32'h8000_0000;
    else if (is_last_blk && cap_k == 4'd14)   cap_word = LEN[63:32];
    else if (is_last_blk && cap_k == 4'd15)   cap_word = LEN[31:0];
    else                                      cap_word = 32'd0;
  end

  // Word buffer flattened onto the block bus, word 0 in the top bits
  always_comb begin
    bus.blk_data = '0;
    for (int i = 0; i < 16; i++) bus.blk_data[511 - 32*i -: 32] = words_q[i];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath: read issue, word capture, block flags and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q         <= 5'd0;
      blk_q         <= 8'd0;
      base_q        <= 16'd0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= 16'd0;
      bus.blk_valid <= 1'b0;
      bus.blk_last  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      for (int i = 0; i < 16; i++) words_q[i] <= 32'd0;
    end else begin
      bus.done      <= finish;
      // Pad slots still take their cycle but never touch memory
      bus.mem_rd_en <= issue && (issue_g < N12);
      if (issue) bus.mem_addr <= issue_base + {4'd0, issue_g};
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            base_q   <= bus.input_addr;
            blk_q    <= 8'd0;
            cyc_q    <= 5'd1;
            bus.busy <= 1'b1;
          end
        end
        FETCH: begin
          cyc_q <= cyc_q + 5'd1;
          if (cyc_q >= 5'd2) words_q[cap_k] <= cap_word;
          if (cyc_q == 5'd17) begin
            bus.blk_valid <= 1'b1;
            bus.blk_last  <= is_last_blk;
          end
        end
        HOLD: begin
          if (bus.blk_ready) begin
            bus.blk_valid <= 1'b0;
            bus.blk_last  <= 1'b0;
            if (is_last_blk) begin
              bus.busy <= 1'b0;
            end else begin
              blk_q <= blk_q + 8'd1;
              cyc_q <= 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.blk_index = blk_q;

endmodule

// File: tb/tb_sha256_block_padder.sv
// tb_sha256_block_padder: three padder instances (N = 40, 14, 1) on one
// shared message memory; directed vector table plus randomized messages
// checked against a block model built from the padding rules.
module tb_sha256_block_padder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  sha256_block_padder_if i40();
  sha256_block_padder_if i14();
  sha256_block_padder_if i1();
  logic [1:0] dbg40, dbg14, dbg1;

  sha256_block_padder #(.NUM_OF_WORDS(40)) u40 (.clk(clk), .rst(rst), .bus(i40), .dbg_state(dbg40));
  sha256_block_padder #(.NUM_OF_WORDS(14)) u14 (.clk(clk), .rst(rst), .bus(i14), .dbg_state(dbg14));
  sha256_block_padder #(.NUM_OF_WORDS(1))  u1  (.clk(clk), .rst(rst), .bus(i1),  .dbg_state(dbg1));

  // ---------------- shared inputs and memory ----------------
  logic [2:0]  start_v = 3'b000;
  logic [15:0] in_addr = 16'd0;
  logic        ready   = 1'b0;
  logic [31:0] mem [65536];
  int rd0 = 0, rd1 = 0, rd2 = 0;

  assign i40.start = start_v[0];  assign i40.input_addr = in_addr;  assign i40.blk_ready = ready;
  assign i14.start = start_v[1];  assign i14.input_addr = in_addr;  assign i14.blk_ready = ready;
  assign i1.start  = start_v[2];  assign i1.input_addr  = in_addr;  assign i1.blk_ready  = ready;

  always @(posedge clk) if (i40.mem_rd_en) begin i40.mem_rd_data <= mem[i40.mem_addr]; rd0 <= rd0 + 1; end
  always @(posedge clk) if (i14.mem_rd_en) begin i14.mem_rd_data <= mem[i14.mem_addr]; rd1 <= rd1 + 1; end
  always @(posedge clk) if (i1.mem_rd_en)  begin i1.mem_rd_data  <= mem[i1.mem_addr];  rd2 <= rd2 + 1; end

  // Selected instance view
  int cur = 0;
  logic         m_valid, m_last, m_busy, m_done;
  logic [7:0]   m_index;
  logic [511:0] m_data;
  always_comb begin
    m_valid = i40.blk_valid; m_last = i40.blk_last; m_busy = i40.busy;
    m_done  = i40.done;      m_index = i40.blk_index; m_data = i40.blk_data;
    if (cur == 1) begin
      m_valid = i14.blk_valid; m_last = i14.blk_last; m_busy = i14.busy;
      m_done  = i14.done;      m_index = i14.blk_index; m_data = i14.blk_data;
    end else if (cur == 2) begin
      m_valid = i1.blk_valid;  m_last = i1.blk_last;  m_busy = i1.busy;
      m_done  = i1.done;       m_index = i1.blk_index;  m_data = i1.blk_data;
    end
  end

  function automatic int rd_of(input int s);
    if (s == 0) return rd0;
    if (s == 1) return rd1;
    return rd2;
  endfunction

  function automatic int n_of(input int s);
    if (s == 0) return 40;
    if (s == 1) return 14;
    return 1;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] sw(input logic [31:0] x);
`ifdef SHA256_PADDER_BYTESWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  // Block b of an n-word message at base, straight from the padding rules
  function automatic logic [511:0] ref_block(input int n, input logic [15:0] base, input int b);
    logic [511:0] r;
    logic [63:0]  len;
    logic [31:0]  w;
    logic [15:0]  a;
    int nb, g;
    nb  = (32 * n + 65 + 511) / 512;
    len = 64'(32 * n);
    r   = '0;
    for (int k = 0; k < 16; k++) begin
      g = 16 * b + k;
      a = base + 16'(g);
      if (g < n)                        w = sw(mem[a]);
      else if (g == n)                  w = 32'h8000_0000;
      else if (b == nb - 1 && k == 14)  w = len[63:32];
      else if (b == nb - 1 && k == 15)  w = len[31:0];
      else                              w = 32'd0;
      r[511 - 32*k -: 32] = w;
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [511:0] got_q [8];

  task automatic pulse_reset();
    #1 rst = 1'b1;
    start_v = 3'b000;
    ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic fill_mem(input int n, input logic [15:0] base);
    for (int g = 0; g < n; g++) mem[base + 16'(g)] = $urandom;
  endtask

  // ---------------- driver: one whole message ----------------
  task automatic run_msg(input int sel, input logic [15:0] base, input int stall, input bit poke);
    int n, nb, cnt, rd_before;
    logic [511:0] exp;
    bit stable;
    cur       = sel;
    n         = n_of(sel);
    nb        = (32 * n + 65 + 511) / 512;
    rd_before = rd_of(sel);
    in_addr   = base;
    ready     = (stall == 0);
    start_v[sel] = 1'b1;
    @(posedge clk); #1;                         // E0 sampled start
    start_v[sel] = 1'b0;
    for (int b = 0; b < nb; b++) begin
      cnt = 0;
      while (!m_valid && cnt < 60) begin
        if (poke) start_v[sel] = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        cnt++;
      end
      start_v[sel] = 1'b0;
      chk("blk_latency", cnt, 17);
      if (cnt >= 60) begin
        pulse_reset();
        return;
      end
      exp = ref_block(n, base, b);
      chk("blk_data", m_data, exp);
      chk("blk_index", m_index, b);
      chk("blk_last", m_last, (b == nb - 1));
      got_q[b] = m_data;
      if (stall > 0) begin
        stable = 1'b1;
        for (int s = 0; s < stall; s++) begin
          if (poke) start_v[sel] = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          if (!m_valid || m_data !== exp) stable = 1'b0;
        end
        start_v[sel] = 1'b0;
        chk("hold_stable", stable, 1);
        ready = 1'b1;
      end
      @(posedge clk); #1;                       // transfer edge
      chk("done_after_xfer", m_done, (b == nb - 1));
      chk("busy_after_xfer", m_busy, (b != nb - 1));
      chk("valid_after_xfer", m_valid, 0);
      ready = (stall == 0);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", m_done, 0);
    chk("read_count", rd_of(sel) - rd_before, n);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          sel;
    int          blk;
    int          word;
    logic [31:0] val;
    bit          from_mem;
  } vec_t;
  vec_t vt [17];

  task automatic check_table(input int sel);
    logic [511:0] b;
    logic [31:0]  e;
    for (int i = 0; i < 17; i++) begin
      if (vt[i].sel == sel) begin
        b = got_q[vt[i].blk];
        e = vt[i].from_mem ? sw(vt[i].val) : vt[i].val;
        chk($sformatf("vec%0d_blk%0d_w%0d", i, vt[i].blk, vt[i].word), b[511 - 32*vt[i].word -: 32], e);
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int vcnt, sel, stall;
    logic [15:0] base;

    vt[0]  = '{0, 2, 0,  32'h21, 1};
    vt[1]  = '{0, 2, 7,  32'h28, 1};
    vt[2]  = '{0, 2, 8,  32'h8000_0000, 0};
    vt[3]  = '{0, 2, 9,  32'h0, 0};
    vt[4]  = '{0, 2, 14, 32'h0, 0};
    vt[5]  = '{0, 2, 15, 32'h500, 0};
    vt[6]  = '{0, 0, 0,  32'h1, 1};
    vt[7]  = '{0, 1, 15, 32'h20, 1};
    vt[8]  = '{1, 0, 13, 32'hE, 1};
    vt[9]  = '{1, 0, 14, 32'h8000_0000, 0};
    vt[10] = '{1, 0, 15, 32'h0, 0};
    vt[11] = '{1, 1, 0,  32'h0, 0};
    vt[12] = '{1, 1, 15, 32'h1C0, 0};
    vt[13] = '{2, 0, 0,  32'h1122_3344, 1};
    vt[14] = '{2, 0, 1,  32'h8000_0000, 0};
    vt[15] = '{2, 0, 2,  32'h0, 0};
    vt[16] = '{2, 0, 15, 32'h20, 0};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {i40.blk_valid, i40.blk_last, i40.blk_index, i40.mem_rd_en,
                        i40.mem_addr, i40.busy, i40.done, dbg40}, 0);
    chk("rst_blk_data", i40.blk_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // N=40, word g = g+1, ready held high
    for (int g = 0; g < 40; g++) mem[16'h1000 + 16'(g)] = 32'(g + 1);
    run_msg(0, 16'h1000, 0, 0);
    check_table(0);

    // N=14: second block is pure padding, only 14 reads
    for (int g = 0; g < 14; g++) mem[16'h2000 + 16'(g)] = 32'(g + 1);
    run_msg(1, 16'h2000, 0, 0);
    check_table(1);

    // N=1 at the top of the address space
    mem[16'hFFFF] = 32'h1122_3344;
    mem[16'h0000] = 32'hDEAD_BEEF;
    run_msg(2, 16'hFFFF, 0, 0);
    check_table(2);

    // N=40 with 10-cycle stalls and start pokes during FETCH/HOLD
    fill_mem(40, 16'h3000);
    run_msg(0, 16'h3000, 10, 1);

    // Reset on E9 of block 1 aborts the message
    cur = 0;
    fill_mem(40, 16'h4000);
    in_addr = 16'h4000; ready = 1'b1; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    vcnt = 0;
    while (!m_valid && vcnt < 60) begin @(posedge clk); #1; vcnt++; end
    chk("pre_rst_latency", vcnt, 17);
    @(posedge clk);                             // transfer edge of block 0
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_outputs", {i40.blk_valid, i40.blk_last, i40.blk_index, i40.mem_rd_en,
                          i40.mem_addr, i40.busy, i40.done, dbg40}, 0);
    chk("abort_blk_data", i40.blk_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 40; c++) begin @(posedge clk); #1; if (m_valid || m_busy) vcnt++; end
    chk("no_partial_block", vcnt, 0);
    run_msg(0, 16'h4000, 0, 0);

    // Randomized messages
    for (int r = 0; r < 12; r++) begin
      sel   = $urandom_range(0, 2);
      base  = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                          : 16'($urandom);
      stall = $urandom_range(0, 3);
      fill_mem(n_of(sel), base);
      run_msg(sel, base, stall, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_block_padder.md
# sha256_block_padder

Upstream feeder for the SHA-256 compression core. Reads a message of `NUM_OF_WORDS` 32-bit words from word-addressed memory and applies SHA-256 padding: a single 1 bit, zero fill, and a 64-bit bit-length. It presents the result one 512-bit block at a time over a valid/ready handshake, so the core only ever sees complete, padded blocks.

## Interface
- `NUM_OF_WORDS`, default 40: message length in 32-bit words; must be at least 1.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin a message; sampled only in IDLE.
- `input_addr` input 16: word address of message word 0; latched when `start` is accepted.
- `mem_rd_en` output 1: memory read strobe (registered).
- `mem_addr` output 16: read address (registered).
- `mem_rd_data` input 32: read data, valid one cycle after the address cycle (synchronous memory).
- `blk_valid` output 1: `blk_data` holds a complete block.
- `blk_ready` input 1: the core accepts the block.
- `blk_data` output 512: word 0 in [511:480], word 15 in [31:0].
- `blk_index` output 8: block number, starting at 0.
- `blk_last` output 1: the block is the final block; qualified by `blk_valid`.
- `busy` output 1: high from start acceptance until `done`.
- `done` output 1: one-cycle pulse when the last block transfers.

## Operation
- `NB` = ceil((32·`NUM_OF_WORDS` + 65) / 512); computed at elaboration.
- `L` = 32·`NUM_OF_WORDS`, expressed as a 64-bit value.
- Global slot index g = 16·block + k, where k = 0..15. Slot content:
  - g < N: memory word at `input_addr` + g. Address arithmetic is modulo 2^16, so it wraps.
  - g == N: 32'h80000000.
  - Last block, k = 14: L[63:32].
  - Last block, k = 15: L[31:0].
  - Otherwise: 0.
- States:
  - IDLE: `start` → FETCH; latch `input_addr`; clear block count.
  - FETCH: 16 slot cycles, then 1 drain cycle; then → HOLD.
  - HOLD: `blk_valid` = 1. On `blk_valid` & `blk_ready`:
    - not last → FETCH for the next block;
    - last → IDLE, with `done` pulsed.
- `mem_rd_en` is high only in slot cycles whose g < N. Pad slots issue no read but still take one cycle, so every block's timing is uniform.
- `blk_data` is a single buffer. It is written word by word during FETCH and held stable throughout HOLD.
- `start` is ignored when not in IDLE. A held `start` in IDLE after `done` begins a new message.
- Reset values, all outputs 0: `blk_valid`, `blk_last`, `blk_index`, `blk_data`, `mem_rd_en`, `mem_addr`, `busy`, `done`. State is IDLE.
- Reset asserted mid-message aborts it immediately. No partial block is ever presented afterwards.

## Timing
- Let E0 be the edge that samples `start`.
- Address for slot k of block 0 is registered at E(k); its data is captured at E(k+2).
- `blk_valid` is high after E17.
- Next block: slot-0 address is registered on the transfer edge T; `blk_valid` is high again after T+17.
- `blk_valid` falls after the transfer edge. It never drops without a transfer.
- `blk_ready` is ignored outside HOLD. `blk_ready` held high gives NB·17 + (NB−1)·0 extra stall, i.e. back-to-back 17-cycle blocks.
- `done` is high for exactly the cycle after the final transfer edge. `busy` falls on the same edge `done` rises.

## Configuration
- `SHA256_PADDER_BYTESWAP_EN` defined: each memory-sourced word is byte-reversed before storage ({b0,b1,b2,b3}), for little-endian message memories. Pad and length words are never swapped. Timing is unchanged.
- `SHA256_PADDER_BYTESWAP_EN` undefined: memory words are stored as read.

## Test plan
- N=40, mem[`input_addr`+g] = g+1, `blk_ready` = 1 → 3 blocks, indices 0/1/2, `blk_last` only on index 2.
  - Block 2 words 0..7 = 0x21..0x28; word 8 = 0x80000000; words 9..14 = 0; word 15 = 0x00000500.
  - `done` pulses once.
- N=14 → block 0: words 0..13 from memory, word 14 = 0x80000000, word 15 = 0. Block 1: all zero except word 15 = 0x000001C0. Check that g ≥ 14 issues no reads.
- N=1, `input_addr` = 16'hFFFF → one block: word 0 = mem[FFFF], word 1 = 0x80000000, word 15 = 0x20. `blk_valid` after E17.
- N=40, `blk_ready` low for 10 cycles in each HOLD → `blk_data` stable while waiting; next `blk_valid` exactly 17 edges after each transfer.
- `rst` pulsed at E9 of block 1 → all outputs 0 next cycle. A new `start` restarts from block 0 and produces correct data.
- `start` pulsed during FETCH/HOLD → ignored; with the macro defined, mem word 0x11223344 appears as 0x44332211.
